// File: rtl/pkt_chan_bridge.sv
// rtl/pkt_chan_bridge.sv - multi-channel FIFO bridge arbitrating producers onto one registered put port
// Each channel owns a small FIFO; a single output register is refilled by a round-robin or fixed-priority arbiter.
module pkt_chan_bridge #(
   parameter int NCHAN    = 4,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 16,
   parameter int ARB_MODE = 0
) (
   input  logic                       nvdla_core_clk,
   input  logic                       nvdla_core_rstn,
   input  logic [NCHAN-1:0]           in_valid,
   output logic [NCHAN-1:0]           in_ready,
   input  logic [NCHAN*DATA_W-1:0]    in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(NCHAN)-1:0]   out_chan,
   output logic [CNT_W-1:0]           xfer_cnt,
   output logic [NCHAN-1:0]           fifo_empty
);
   localparam int CH_W  = $clog2(NCHAN);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   logic [DATA_W-1:0] mem    [NCHAN][DEPTH];
   logic [PTR_W-1:0]  wr_ptr [NCHAN];
   logic [PTR_W-1:0]  rd_ptr [NCHAN];
   logic [CW-1:0]     count  [NCHAN];
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   grant_idx;
   logic              grant_any;
   logic              slot_free;
   logic [NCHAN-1:0]  push;
   logic [NCHAN-1:0]  pop;

   // Readiness comes only from registered counts, so out_ready never reaches in_ready.
   always_comb begin
      in_ready   = '0;
      fifo_empty = '0;
      for (int i = 0; i < NCHAN; i++) begin
         in_ready[i]   = (count[i] != CW'(DEPTH));
         fifo_empty[i] = (count[i] == '0);
      end
   end

   assign slot_free = !out_valid || out_ready;

   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      if (ARB_MODE == 1) begin
         for (int i = NCHAN - 1; i >= 0; i--) begin
            if (count[i] != '0) begin
               grant_any = 1'b1;
               grant_idx = CH_W'(i);
            end
         end
      end else begin
         for (int k = 0; k < NCHAN; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NCHAN) idx = idx - NCHAN;
            if (!grant_any && count[idx] != '0) begin
               grant_any = 1'b1;
               grant_idx = CH_W'(idx);
            end
         end
      end
   end

   always_comb begin
      push = '0;
      pop  = '0;
      for (int i = 0; i < NCHAN; i++) begin
         push[i] = in_valid[i] && in_ready[i];
         pop[i]  = slot_free && grant_any && (grant_idx == CH_W'(i));
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      for (int i = 0; i < NCHAN; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         for (int i = 0; i < NCHAN; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NCHAN; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
            else if (!push[i] && pop[i]) count[i] <= count[i] - CW'(1);
         end
      end
   end

   // Output slot: refilled whenever it is empty or being drained this cycle.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         xfer_cnt  <= '0;
         rr_ptr    <= '0;
      end else begin
         if (out_valid && out_ready) xfer_cnt <= xfer_cnt + CNT_W'(1);
         if (slot_free) begin
            if (grant_any) begin
               out_valid <= 1'b1;
               out_data  <= mem[grant_idx][rd_ptr[grant_idx]];
               out_chan  <= grant_idx;
               if (ARB_MODE == 0)
                  rr_ptr <= (grant_idx == CH_W'(NCHAN - 1)) ? '0 : grant_idx + CH_W'(1);
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_pkt_chan_bridge.sv
// tb/tb_pkt_chan_bridge.sv - directed bench for pkt_chan_bridge, round-robin and fixed-priority instances
// A queue-based reference model is compared every cycle; test-plan sequences are pinned with literals.
module tb_pkt_chan_bridge;
   logic         clk = 1'b0;
   logic         rstn;
   logic [3:0]   in_valid;
   logic [127:0] in_data;
   logic         out_ready;
   logic [3:0]   ir [2];
   logic         ov [2];
   logic [31:0]  od [2];
   logic [1:0]   oc [2];
   logic [3:0]   fe [2];
   logic [3:0]   xc_rr;
   logic [15:0]  xc_fp;

   int n_cmp = 0;
   int n_err = 0;

   pkt_chan_bridge #(.NCHAN(4), .DATA_W(32), .DEPTH(4), .CNT_W(4), .ARB_MODE(0)) u_rr (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
      .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_chan(oc[0]),
      .xfer_cnt(xc_rr), .fifo_empty(fe[0]));

   pkt_chan_bridge #(.NCHAN(4), .DATA_W(32), .DEPTH(4), .CNT_W(16), .ARB_MODE(1)) u_fp (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
      .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_chan(oc[1]),
      .xfer_cnt(xc_fp), .fifo_empty(fe[1]));

   always #5 clk = ~clk;

   // Reference model: instance m uses queues mq[m*4+c]; instance 0 is round-robin, 1 is fixed priority.
   logic [31:0] mq [8][$];
   logic        m_valid [2] = '{0, 0};
   logic [31:0] m_data  [2] = '{0, 0};
   int          m_chan  [2] = '{0, 0};
   int          m_rr    [2] = '{0, 0};
   int          m_xfer  [2] = '{0, 0};
   int          m_mod   [2] = '{16, 65536};
   int          lch  [2][$];
   logic [31:0] ldat [2][$];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int q = 0; q < 8; q++) mq[q].delete();
         for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_data[m] = 0; m_chan[m] = 0; m_rr[m] = 0; m_xfer[m] = 0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            bit acc [4];
            int g;
            for (int c = 0; c < 4; c++) acc[c] = in_valid[c] && (mq[m*4+c].size() != 4);
            if (m_valid[m] && out_ready) m_xfer[m] = (m_xfer[m] + 1) % m_mod[m];
            if (!m_valid[m] || out_ready) begin
               g = -1;
               for (int k = 0; k < 4; k++) begin
                  int c;
                  c = (m == 1) ? k : (m_rr[m] + k) % 4;
                  if (g < 0 && mq[m*4+c].size() > 0) g = c;
               end
               if (g >= 0) begin
                  m_data[m]  = mq[m*4+g].pop_front();
                  m_chan[m]  = g;
                  m_valid[m] = 1;
                  if (m == 0) m_rr[m] = (g + 1) % 4;
               end else begin
                  m_valid[m] = 0;
               end
            end
            for (int c = 0; c < 4; c++) if (acc[c]) mq[m*4+c].push_back(in_data[c*32 +: 32]);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         for (int m = 0; m < 2; m++) begin
            logic [3:0] e_ir, e_fe;
            for (int c = 0; c < 4; c++) begin
               e_ir[c] = (mq[m*4+c].size() != 4);
               e_fe[c] = (mq[m*4+c].size() == 0);
            end
            chk($sformatf("u%0d out_valid", m), 64'(ov[m]), 64'(m_valid[m]));
            chk($sformatf("u%0d out_data", m), 64'(od[m]), 64'(m_data[m]));
            chk($sformatf("u%0d out_chan", m), 64'(oc[m]), 64'(m_chan[m]));
            chk($sformatf("u%0d xfer_cnt", m), 64'((m == 0) ? xc_rr : xc_fp), 64'(m_xfer[m]));
            chk($sformatf("u%0d in_ready", m), 64'(ir[m]), 64'(e_ir));
            chk($sformatf("u%0d fifo_empty", m), 64'(fe[m]), 64'(e_fe));
            if (ov[m] === 1'b1 && out_ready === 1'b1) begin
               lch[m].push_back(int'(oc[m]));
               ldat[m].push_back(od[m]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; in_valid = '0; out_ready = 1'b0;
      tick();
      rstn = 1'b1;
      for (int m = 0; m < 2; m++) begin lch[m].delete(); ldat[m].delete(); end
   endtask

   task automatic push(input logic [3:0] mask, input int j);
      in_valid = mask;
      for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = 32'hC000_0000 | (c << 8) | j;
      tick();
      in_valid = '0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(ov[0] == 1'b0 && ov[1] == 1'b0 && fe[0] == 4'hF && fe[1] == 4'hF) && t < 80) begin
         tick();
         t++;
      end
      chk("drain within budget", 64'(t < 80), 64'd1);
   endtask

   task automatic check_seq(input int m, input string nm, input int n, input logic [31:0] seq);
      chk($sformatf("%s u%0d count", nm, m), 64'(lch[m].size()), 64'(n));
      for (int k = 0; k < n && k < lch[m].size(); k++)
         chk($sformatf("%s u%0d chan[%0d]", nm, m, k), 64'(lch[m][k]), 64'((seq >> (4*(n-1-k))) & 32'hF));
   endtask

   initial begin
      rstn = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("reset u%0d out_valid", m), 64'(ov[m]), 64'd0);
         chk($sformatf("reset u%0d in_ready", m), 64'(ir[m]), 64'hF);
         chk($sformatf("reset u%0d fifo_empty", m), 64'(fe[m]), 64'hF);
      end
      chk("reset u0 xfer_cnt", 64'(xc_rr), 64'd0);
      chk("reset u1 xfer_cnt", 64'(xc_fp), 64'd0);
      rstn = 1'b1;

      // Single-channel latency on ch2.
      out_ready = 1'b1;
      in_valid = 4'b0100;
      in_data[64 +: 32] = 32'hA5A5_0001;
      tick();
      in_valid = '0;
      tick();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("lat u%0d out_valid", m), 64'(ov[m]), 64'd1);
         chk($sformatf("lat u%0d out_data", m), 64'(od[m]), 64'hA5A5_0001);
         chk($sformatf("lat u%0d out_chan", m), 64'(oc[m]), 64'd2);
      end
      tick();
      chk("lat u0 xfer_cnt", 64'(xc_rr), 64'd1);
      chk("lat u1 xfer_cnt", 64'(xc_fp), 64'd1);

      // Two words on every channel.
      do_reset();
      push(4'hF, 0); push(4'hF, 1); tick();
      out_ready = 1'b1; wait_idle(); out_ready = 1'b0;
      check_seq(0, "rr4", 8, 32'h0123_0123);
      check_seq(1, "fp4", 8, 32'h0011_2233);
      if (ldat[0].size() == 8) begin
         chk("rr4 u0 data[0]", 64'(ldat[0][0]), 64'hC000_0000);
         chk("rr4 u0 data[4]", 64'(ldat[0][4]), 64'hC000_0001);
         chk("rr4 u0 data[7]", 64'(ldat[0][7]), 64'hC000_0301);
      end

      // Only ch1 and ch3 loaded.
      do_reset();
      push(4'b1010, 0); push(4'b1010, 1); tick();
      out_ready = 1'b1; wait_idle(); out_ready = 1'b0;
      check_seq(0, "rr13", 4, 32'h1313);
      check_seq(1, "fp13", 4, 32'h1133);

      // ch0 with three words, ch3 with one.
      do_reset();
      push(4'b1001, 0); push(4'b0001, 1); push(4'b0001, 2);
      out_ready = 1'b1; wait_idle(); out_ready = 1'b0;
      check_seq(0, "pri", 4, 32'h0300);
      check_seq(1, "pri", 4, 32'h0003);
      if (ldat[1].size() == 4) chk("pri u1 data[2]", 64'(ldat[1][2]), 64'hC000_0002);

      // Backpressure into ch1 until full.
      do_reset();
      for (int j = 0; j < 6; j++) begin
         in_valid = 4'b0010;
         in_data[32 +: 32] = 32'hC000_0100 | j;
         tick();
         if (j == 3) begin
            chk("bp u0 in_ready not yet full", 64'(ir[0]), 64'hF);
            chk("bp u1 in_ready not yet full", 64'(ir[1]), 64'hF);
         end
         if (j == 4) begin
            chk("bp u0 in_ready full", 64'(ir[0]), 64'hD);
            chk("bp u1 in_ready full", 64'(ir[1]), 64'hD);
         end
      end
      in_valid = '0;
      chk("bp u0 held data", 64'(od[0]), 64'hC000_0100);
      chk("bp u1 held data", 64'(od[1]), 64'hC000_0100);
      out_ready = 1'b1; wait_idle(); out_ready = 1'b0;
      for (int m = 0; m < 2; m++) begin
         check_seq(m, "bp", 5, 32'h11111);
         for (int k = 0; k < 5 && k < ldat[m].size(); k++)
            chk($sformatf("bp u%0d data[%0d]", m, k), 64'(ldat[m][k]), 64'(32'hC000_0100 | k));
      end

      // Transfer counter wrap on the 4-bit instance.
      do_reset();
      out_ready = 1'b1;
      in_valid = 4'b0001;
      for (int j = 0; j < 15; j++) begin
         in_data[31:0] = 32'hC000_0000 | j;
         tick();
      end
      in_valid = '0;
      wait_idle();
      chk("wrap 15 u0", 64'(xc_rr), 64'd15);
      chk("wrap 15 u1", 64'(xc_fp), 64'd15);
      push(4'b0001, 15); wait_idle();
      chk("wrap 16 u0", 64'(xc_rr), 64'd0);
      chk("wrap 16 u1", 64'(xc_fp), 64'd16);
      push(4'b0001, 16); wait_idle();
      chk("wrap 17 u0", 64'(xc_rr), 64'd1);
      chk("wrap 17 u1", 64'(xc_fp), 64'd17);

      // Reset asserted between edges in the middle of a burst.
      do_reset();
      push(4'hF, 0); push(4'hF, 1);
      out_ready = 1'b1;
      tick();
      chk("midrst u0 busy", 64'(ov[0]), 64'd1);
      #3 rstn = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("midrst u%0d out_valid", m), 64'(ov[m]), 64'd0);
         chk($sformatf("midrst u%0d fifo_empty", m), 64'(fe[m]), 64'hF);
      end
      chk("midrst u0 xfer_cnt", 64'(xc_rr), 64'd0);
      tick();
      rstn = 1'b1;
      out_ready = 1'b0;
      repeat (3) tick();
      chk("midrst u0 stays idle", 64'(ov[0]), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pkt_chan_bridge.md
# pkt_chan_bridge

Multi-channel blocking-put bridge. It gathers packet words from NCHAN independent producer channels and buffers each channel in its own FIFO. It then arbitrates the channels onto a single registered put interface, which is the hardware counterpart of several producers bound to one consumer port. It sits between per-channel packet sources and a shared downstream transport, and tags every output word with its source channel.

## Interface
- NCHAN, 4: number of input channels (2..8).
- DATA_W, 32: packet word width.
- DEPTH, 4: per-channel FIFO depth in words; a power of two, ≥2.
- CNT_W, 16: width of the output transfer counter.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- nvdla_core_clk  in  1  single clock; all state updates on the rising edge.
- nvdla_core_rstn  in  1  asynchronous, active-low reset.
- in_valid  in  NCHAN  per-channel put request.
- in_ready  out  NCHAN  per-channel FIFO not full.
- in_data  in  NCHAN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  output word.
- out_chan  out  clog2(NCHAN)  source channel of out_data.
- xfer_cnt  out  CNT_W  count of completed output transfers; wraps.
- fifo_empty  out  NCHAN  per-channel FIFO empty status.

## Operation
- Reset is asynchronous and active-low. On reset, all FIFOs are flushed and pointers and counts are zeroed. The round-robin pointer resets to 0.
- Output reset values: out_valid=0, out_data=0, out_chan=0, xfer_cnt=0, in_ready=all 1, fifo_empty=all 1.
- Input handshake: a word is accepted on channel i when in_valid[i] && in_ready[i] at a clock edge.
- in_ready[i] depends only on the registered count[i] != DEPTH. A full FIFO never accepts a word, even if it is popped in the same cycle.
- Output slot: a single register stage.
  - The slot is free when out_valid=0, or when out_valid && out_ready (drain this cycle).
  - While out_valid=1 && out_ready=0, out_data and out_chan are held stable.
- Arbitration: the arbiter evaluates each cycle the slot is free, over channels with count[i]!=0 as seen at the start of that cycle.
  - Mode 0: the search starts at rr_ptr and wraps modulo NCHAN. After a grant to channel g, rr_ptr := (g+1) mod NCHAN.
  - Mode 1: lowest index wins and rr_ptr is unused.
- On a grant, the FIFO head is popped and loaded into out_data. out_chan is set to g and out_valid is set to 1.
- If the slot is free and no channel is eligible, out_valid becomes 0. out_data and out_chan keep their last values.
- Each FIFO supports a simultaneous push and pop in the same cycle: count is unchanged and data order is preserved.
- There is no bypass. A word pushed into an empty FIFO cannot be granted in the same cycle.
- xfer_cnt increments by 1 on each out_valid && out_ready edge and wraps from 2^CNT_W-1 to 0.
- Per-channel ordering is strictly FIFO. Interleaving across channels is set only by the arbiter.

## Timing
- Minimum latency: a word accepted at edge k appears on out_valid/out_data after edge k+1, provided the slot was free and the channel won arbitration.
- Throughput is one output word per cycle while out_ready=1 and any FIFO is non-empty.
- Each channel sustains one word per cycle in, as long as its FIFO has space.
- There is no combinational path from in_valid/in_data to out_*, nor from out_ready to in_ready.
- fifo_empty[i] is registered and reflects count[i]==0 after each edge.
- Reset during a transfer:
  - out_valid drops asynchronously and any word in flight is discarded.
  - After rstn is released, the first grant occurs no earlier than 2 edges after the first accepted input.
- Every FIFO full with out_ready=0 gives in_ready=0 on all channels and leaves all state frozen except input sampling.
- Pointer wrap: FIFO read and write pointers wrap modulo DEPTH. count has clog2(DEPTH)+1 bits to distinguish full from empty.

## Test plan
- Reset values: hold rstn low, then release. Expect out_valid=0, xfer_cnt=0, in_ready=4'b1111, fifo_empty=4'b1111. Assert rstn mid-burst and expect out_valid=0 immediately.
- Single-channel latency: push 0xA5A5_0001 on ch2 at edge k with out_ready=1. Expect out_valid=1, out_data=0xA5A5_0001, out_chan=2 after edge k+1, and xfer_cnt=1 after edge k+2.
- Round-robin fairness (ARB_MODE=0):
  - Preload 2 words on each of ch0..3, then raise out_ready. Expect out_chan sequence 0,1,2,3,0,1,2,3.
  - Preload only ch1 and ch3, then raise out_ready. Expect 1,3,1,3.
- Fixed priority (ARB_MODE=1): preload ch0 with 3 words and ch3 with 1 word. Expect out_chan 0,0,0,3.
- Backpressure and full:
  - Hold out_ready=0 and push 5 words into ch1 (DEPTH=4). Expect in_ready[1]=0 after the 4th accepted word, or the 5th if the output slot absorbed one.
  - Expect out_data to stay stable throughout. Release out_ready and expect all words in order with none lost.
- Counter wrap (CNT_W=4): complete 17 transfers. Expect xfer_cnt to read 15 and then 0 after the 16th, and 1 after the 17th.
